fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream drain stage for the byte FIFO: pulls one word at a time from the FIFO read port and serialises it as an asynchronous UART frame (start, DATA_WIDTH data bits LSB first, optional even parity, one stop bit). Sits directly after the FIFO on the transmit path and drives the board TX pin. It consumes the FIFO's registered read data, which is valid one cycle after `rd_en`.

## Interface
- `DATA_WIDTH`, 8: width of FIFO word and UART data field.
- `CLKS_PER_BIT`, 868: clk cycles per UART bit; legal range ≥2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after the data bits.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `enable` in 1: permits starting a new frame; it does not abort a frame in progress.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: one-cycle read strobe to the FIFO.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high whenever state ≠ IDLE.
- `frames_sent` out 16: count of completed frames, wraps at 0xFFFF→0.

## Operation
- **States:** IDLE, FETCH, START, DATA, PARITY, STOP.
- **IDLE:**
  - `fifo_rd_en = enable && !fifo_empty`. This is combinational from state and inputs.
  - If asserted, go to FETCH. Otherwise stay.
- **FETCH:** latch `fifo_dout` into the shift register, clear the bit counter, then go to START. This state lasts exactly 1 cycle.
- **START:** `tx=0` for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - `tx` = shift register bit 0. Shift right every CLKS_PER_BIT cycles.
  - After DATA_WIDTH bits, go to PARITY if PARITY_EN, else STOP.
- **PARITY:** `tx` = XOR of the latched word, for CLKS_PER_BIT cycles. This makes the total count of ones even.
- **STOP:** `tx=1` for CLKS_PER_BIT cycles. On the last cycle, increment `frames_sent` and go to IDLE.
- **Strobe width:** `fifo_rd_en` never stays high for more than 1 cycle. It is never asserted outside IDLE.
- **Empty FIFO:** `fifo_rd_en` is never asserted while `fifo_empty=1`.
- **enable dropped mid-frame:** the current frame completes. No new read is issued.
- **fifo_empty rising after the read:** has no effect; the word is already latched.
- **Reset mid-frame:** on the next cycle, state=IDLE, `tx=1`, and the baud and bit counters are 0. The partially sent word is discarded and not re-read.
- **Baud counter:** width ceil(log2(CLKS_PER_BIT)). It counts 0..CLKS_PER_BIT-1 and reloads to 0 on each state change.
- **Bit counter:** width ceil(log2(DATA_WIDTH+1)).

## Timing
- **Reset values:** `tx=1`, `busy=0`, `fifo_rd_en=0`, `frames_sent=0`, state IDLE.
- **`tx` is registered.** It changes only on clk edges.
- **Frame timeline.** Let the read strobe be at cycle T.
  - T+1: FETCH.
  - T+2 .. T+1+CLKS_PER_BIT: `tx` low (start bit).
  - Data bit i: starts at T+2+(1+i)·CLKS_PER_BIT.
  - Frame end: T+1+F·CLKS_PER_BIT, where F = 2+DATA_WIDTH+PARITY_EN.
- **`busy`:** high from T+1 through the last STOP cycle inclusive.
- **Back-to-back frames:** with the FIFO non-empty and `enable=1`, exactly 2 extra idle-high cycles (IDLE, FETCH) separate a stop bit from the next start bit.
- **`frames_sent`:** updates on the clock edge that ends STOP.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding constants (3-bit localparams for the six states);
  - `clog2` function;
  - idle line level constant (1).
- **One sub-module, `uart_baud_tick`:**
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `reset`, `restart`;
  - output `bit_done`, pulsed on count CLKS_PER_BIT-1.
  - The FSM pulses `restart` on every state transition.
- **Top level:** FSM, shift register, parity register, bit counter, frame counter.

## Test plan
Unless stated otherwise, benches use CLKS_PER_BIT=4, DATA_WIDTH=8 and a behavioural FIFO model with 1-cycle read latency.

- **Reset:** hold `reset` for 3 cycles with the FIFO non-empty → `tx=1`, `fifo_rd_en=0`, `busy=0`, `frames_sent=0` throughout.
- **Single frame:** FIFO holds 0xA5, `enable=1` → one `rd_en` pulse at T.
  - `tx` low for T+2..T+5.
  - Then bits 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Then high for 4 cycles.
  - `busy` falls after T+41; `frames_sent=1`.
- **Back-to-back:** FIFO holds 0x00, 0xFF → two `rd_en` pulses 42 cycles apart. Exactly 2 high cycles separate the first stop bit from the second start bit; `frames_sent=2`.
- **Empty / disabled:**
  - `fifo_empty=1` for 100 cycles → no `rd_en`, `tx=1`.
  - FIFO non-empty with `enable=0` → same result.
  - Drop `enable` mid-frame → the frame completes and no further read occurs.
- **Parity:** PARITY_EN=1, word 0x07 → parity bit 1 after bit 7, stop bit follows, frame is 44 cycles; word 0x03 → parity bit 0.
- **Reset mid-frame:** assert `reset` during data bit 3 → next cycle `tx=1`, `busy=0`, `frames_sent=0`. After release, the next FIFO word is fetched with a fresh `rd_en`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// line level and a constant-evaluable ceil(log2()) helper.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_START  = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_PARITY = 3'd4;
  localparam state_t ST_STOP   = 3'd5;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final count;
// restart forces the next count back to 0 so every state begins a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: reads one word per frame and serialises it as
// start / LSB-first data / optional even parity / stop on a registered tx line.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam int BCW = clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [15:0]             frames_q, frames_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    bit_done;
  logic                    restart;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bit_done(bit_done)
  );

  // Read strobe is only ever raised from IDLE, so it cannot exceed one cycle.
  assign fifo_rd_en = !reset && (state_q == ST_IDLE) && enable && !fifo_empty;
  assign restart    = (state_d != state_q);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    frames_d  = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_rd_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        shift_d   = fifo_dout;
        par_d     = ^fifo_dout;
        bit_cnt_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          frames_d = frames_q + 16'd1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so tx is a clean flop output.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      frames_q  <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frames_q  <= frames_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + randomized bench for fifo_uart_tx: two instances (no parity /
// even parity) fed by queue-style FIFO models, checked against a frame-shape model.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en0, en1;
  logic        e0, e1;
  logic [7:0]  d0, d1;
  logic        rd0, rd1, tx0, tx1, b0, b1;
  logic [15:0] fs0, fs1;

  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  int errors = 0;
  int checks = 0;
  int ef0 = 0;
  int ef1 = 0;

  assign e0 = (wp0 == rp0);
  assign e1 = (wp1 == rp1);

  // FIFO models with one-cycle registered read data
  always @(posedge clk) begin
    if (rd0 && !e0) begin
      d0  <= mem0[rp0 % 64];
      rp0 <= rp0 + 1;
    end
    if (rd1 && !e1) begin
      d1  <= mem1[rp1 % 64];
      rp1 <= rp1 + 1;
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .enable(en0), .fifo_empty(e0), .fifo_dout(d0),
    .fifo_rd_en(rd0), .tx(tx0), .busy(b0), .frames_sent(fs0)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .fifo_empty(e1), .fifo_dout(d1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(b1), .frames_sent(fs1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] w);
    if (sel != 0) begin
      mem1[wp1 % 64] = w;
      wp1++;
    end else begin
      mem0[wp0 % 64] = w;
      wp0++;
    end
  endtask

  // Expected line level k cycles after the read strobe for word w
  function automatic logic exp_tx(input logic [7:0] w, input int k, input int par);
    int idx;
    if (k < 2) return 1'b1;
    idx = (k - 2) / C;
    if (idx == 0) return 1'b0;
    if (idx <= DW) return w[idx-1];
    if (par != 0 && idx == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic check_frame(input int sel, input logic [7:0] w, input int drop_at,
                             input int stop_at, output int waited);
    int   last;
    int   c;
    logic seen;
    last = (2 + DW + sel) * C + 1;
    #1;
    c    = 0;
    seen = (sel != 0) ? rd1 : rd0;
    while (!seen && c < 300) begin
      chk("wait_tx_high", (sel != 0) ? tx1 : tx0, 1'b1);
      @(negedge clk);
      #1;
      c++;
      seen = (sel != 0) ? rd1 : rd0;
    end
    waited = c;
    chk("rd_strobe", seen, 1'b1);
    if (!seen) return;
    for (int k = 1; k <= last && k <= stop_at; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        if (sel != 0) en1 = 1'b0;
        else en0 = 1'b0;
      end
      chk($sformatf("frame_tx s%0d w%02h k=%0d", sel, w, k), (sel != 0) ? tx1 : tx0, exp_tx(w, k, sel));
      chk($sformatf("frame_busy s%0d k=%0d", sel, k), (sel != 0) ? b1 : b0, 1'b1);
      chk($sformatf("frame_rd_low s%0d k=%0d", sel, k), (sel != 0) ? rd1 : rd0, 1'b0);
    end
    if (stop_at >= last) begin
      if (sel != 0) ef1++;
      else ef0++;
    end
  endtask

  task automatic idle_check(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_rd", (sel != 0) ? rd1 : rd0, 1'b0);
      chk("idle_tx", (sel != 0) ? tx1 : tx0, 1'b1);
      chk("idle_busy", (sel != 0) ? b1 : b0, 1'b0);
      chk("idle_frames", (sel != 0) ? fs1 : fs0, (sel != 0) ? ef1 : ef0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w;
    logic [7:0] rw [4];
    logic [7:0] wa, wb, w1, w2;

    reset = 1'b1;
    en0   = 1'b1;
    en1   = 1'b0;
    push(0, 8'hA5);
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx0, 1'b1);
      chk("rst_rd", rd0, 1'b0);
      chk("rst_busy", b0, 1'b0);
      chk("rst_frames", fs0, 16'd0);
    end
    reset = 1'b0;

    // single frame 0xA5
    check_frame(0, 8'hA5, 0, 1000, w);
    idle_check(0, 3);

    // back-to-back 0x00, 0xFF
    push(0, 8'h00);
    push(0, 8'hFF);
    check_frame(0, 8'h00, 0, 1000, w);
    check_frame(0, 8'hFF, 0, 1000, w);
    chk("b2b_gap", w, 1);
    idle_check(0, 2);

    // randomized back-to-back words
    for (int i = 0; i < 4; i++) begin
      rw[i] = 8'($urandom);
      push(0, rw[i]);
    end
    for (int i = 0; i < 4; i++) begin
      check_frame(0, rw[i], 0, 1000, w);
      if (i > 0) chk("rand_gap", w, 1);
    end
    idle_check(0, 2);

    // empty FIFO with enable high
    idle_check(0, 100);

    // non-empty FIFO but disabled; then drop enable mid-frame
    en0 = 1'b0;
    wa  = 8'($urandom);
    wb  = 8'($urandom);
    push(0, wa);
    push(0, wb);
    idle_check(0, 50);
    en0 = 1'b1;
    check_frame(0, wa, 10, 1000, w);
    idle_check(0, 60);
    en0 = 1'b1;
    check_frame(0, wb, 0, 1000, w);
    idle_check(0, 2);

    // even parity instance
    en1 = 1'b1;
    push(1, 8'h07);
    push(1, 8'h03);
    wa = 8'($urandom);
    push(1, wa);
    check_frame(1, 8'h07, 0, 1000, w);
    check_frame(1, 8'h03, 0, 1000, w);
    check_frame(1, wa, 0, 1000, w);
    idle_check(1, 2);

    // reset during data bit 3, next word must be freshly fetched
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    push(0, w1);
    push(0, w2);
    check_frame(0, w1, 0, 19, w);
    reset = 1'b1;
    @(negedge clk);
    ef0 = 0;
    ef1 = 0;
    chk("midrst_tx", tx0, 1'b1);
    chk("midrst_busy", b0, 1'b0);
    chk("midrst_frames", fs0, 16'd0);
    chk("midrst_rd", rd0, 1'b0);
    reset = 1'b0;
    check_frame(0, w2, 0, 1000, w);
    idle_check(0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
